// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/sequence controller for the 8-bit two-register CPU datapath.
// Latency (zero-wait memory): NOP 2, ALU 3, LOAD 4, JMP/JZ 3, HALT 2 cycles; outputs are Moore.
// Backpressure: imem_req is held with a stable address until imem_ack; the FSM stalls in FETCH/OPER meanwhile.
module cpu_control_unit #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_data,
    input  logic [7:0]        temp1,
    input  logic [7:0]        temp2,
    output logic              reg_sel,
    output logic              reg_we,
    output logic              wb_src,
    output logic [1:0]        alu_op,
    output logic [7:0]        imm,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPER, S_WB, S_HALT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    // Only ir[7:4] carries meaning (opcode + register bit); the low nibble is never stored.
    logic [3:0]        ir_hi, ir_hi_nxt;
    logic [7:0]        imm_q, imm_nxt;

    logic [2:0]        opcode;
    logic              r_bit;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [7:0]        jz_val;

    assign opcode = ir_hi[3:1];
    assign r_bit  = ir_hi[0];
    assign pc_inc = pc + ADDR_W'(1);
    assign target = ADDR_W'(imem_data);
    assign jz_val = r_bit ? temp2 : temp1;

    // State, program counter, instruction and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir_hi <= '0;
            imm_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir_hi <= ir_hi_nxt;
            imm_q <= imm_nxt;
        end
    end

    // Next-state and register update logic; memory data is only consumed on an acked request.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_hi_nxt = ir_hi;
        imm_nxt   = imm_q;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_hi_nxt = imem_data[7:4];
                    pc_nxt    = pc_inc;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP:                 state_nxt = S_FETCH;
                    OP_LOAD, OP_JMP, OP_JZ: state_nxt = S_OPER;
                    OP_ADD, OP_SUB, OP_AND: state_nxt = S_WB;
                    OP_HALT:                state_nxt = S_HALT;
                    default:                state_nxt = S_FETCH;
                endcase
            end
            S_OPER: begin
                if (imem_ack) begin
                    state_nxt = S_FETCH;
                    case (opcode)
                        OP_LOAD: begin
                            imm_nxt   = imem_data;
                            pc_nxt    = pc_inc;
                            state_nxt = S_WB;
                        end
                        OP_JMP:  pc_nxt = target;
                        OP_JZ:   pc_nxt = (jz_val == 8'h00) ? target : pc_inc;
                        default: pc_nxt = pc_inc;
                    endcase
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                if (start) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded purely from registered state, ir, imm and pc.
    always_comb begin
        imem_req  = (state == S_FETCH) || (state == S_OPER);
        imem_addr = pc;
        busy      = (state != S_IDLE) && (state != S_HALT);
        halted    = (state == S_HALT);
        reg_we    = (state == S_WB);
        reg_sel   = (state == S_WB) && r_bit;
        wb_src    = (state == S_WB) && (opcode != OP_LOAD);
        imm       = imm_q;
        alu_op    = 2'b00;
        if (state == S_WB) begin
            case (opcode)
                OP_SUB:  alu_op = 2'b01;
                OP_AND:  alu_op = 2'b10;
                default: alu_op = 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: behavioural instruction memory with programmable wait states.
// Scoreboard queues hold expected memory access addresses and register writes, checked by a negedge monitor.
// Scenario tasks run in sequence from one initial block and finish with a single summary line.
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] temp1 = 8'h00;
    logic [7:0] temp2 = 8'h00;
    logic       reg_sel, reg_we, wb_src, busy, halted;
    logic [1:0] alu_op;
    logic [7:0] imm;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       sel;
        logic       src;
        logic [1:0] op;
        logic       chk;
        logic [7:0] imm;
    } wr_t;

    logic [7:0] exp_addr[$];
    wr_t        exp_wr[$];

    logic [7:0] mem [256];
    int         ack_delay = 0;
    int         wait_cnt  = 0;
    logic       stray_ack = 1'b0;

    always #5 clk = ~clk;

    assign imem_ack  = (imem_req && (wait_cnt >= ack_delay)) || stray_ack;
    assign imem_data = mem[imem_addr];

    // Wait-state counter for the memory model.
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    cpu_control_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .temp1(temp1), .temp2(temp2),
        .reg_sel(reg_sel), .reg_we(reg_we), .wb_src(wb_src), .alu_op(alu_op), .imm(imm),
        .busy(busy), .halted(halted)
    );

    // Scoreboard monitor: every accepted access and every register write is matched against the queues.
    always @(negedge clk) begin
        logic [7:0] a;
        wr_t        w;
        if (rst_n && imem_req && imem_ack) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL access_addr unexpected access at %h", imem_addr);
            end else begin
                a = exp_addr.pop_front();
                if (imem_addr !== a) begin
                    errors++;
                    $display("FAIL access_addr got %h expected %h", imem_addr, a);
                end
            end
        end
        if (rst_n && reg_we === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL reg_write unexpected write sel=%b src=%b op=%b", reg_sel, wb_src, alu_op);
            end else begin
                w = exp_wr.pop_front();
                if (reg_sel !== w.sel || wb_src !== w.src || alu_op !== w.op || (w.chk && imm !== w.imm)) begin
                    errors++;
                    $display("FAIL reg_write got sel=%b src=%b op=%b imm=%h expected sel=%b src=%b op=%b imm=%h",
                             reg_sel, wb_src, alu_op, imm, w.sel, w.src, w.op, w.imm);
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic go(output int cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (halted !== 1'b1 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout halted=%b after %0d cycles", halted, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (imem_req !== 1'b0 || reg_we !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 ||
            imem_addr !== 8'h00 || imm !== 8'h00 || reg_sel !== 1'b0 || wb_src !== 1'b0 || alu_op !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs req=%b we=%b busy=%b halted=%b addr=%h imm=%h expected all zero",
                     imem_req, reg_we, busy, halted, imem_addr, imm);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b req=%b expected 0 0", busy, imem_req);
        end
    endtask

    task automatic test_program();
        int cyc;
        mem[0] = 8'h20; mem[1] = 8'h05; mem[2] = 8'h30; mem[3] = 8'h03; mem[4] = 8'h40; mem[5] = 8'hE0;
        for (int i = 0; i < 6; i++) exp_addr.push_back(8'(i));
        exp_wr.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 8'h05});
        exp_wr.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 8'h03});
        exp_wr.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 8'h00});
        go(cyc);
        checks++;
        if (cyc != 13) begin
            errors++;
            $display("FAIL program_latency got %0d cycles expected 13", cyc);
        end
        checks++;
        if (imem_addr !== 8'h06 || busy !== 1'b0) begin
            errors++;
            $display("FAIL program_halt_pc pc=%h busy=%b expected 06 0", imem_addr, busy);
        end
        checks++;
        if (exp_addr.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL program_drain addr_left=%0d wr_left=%0d expected 0", exp_addr.size(), exp_wr.size());
        end
    endtask

    task automatic test_reset_mid_handshake();
        ack_delay = 50;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h06) begin
            errors++;
            $display("FAIL mid_fetch req=%b addr=%h expected 1 06", imem_req, imem_addr);
        end
        rst_n = 1'b0;
        stray_ack = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || reg_we !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid req=%b we=%b busy=%b halted=%b addr=%h expected 0 0 0 0 00",
                     imem_req, reg_we, busy, halted, imem_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray_ack = 1'b0;
        ack_delay = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'h00) begin
                errors++;
                $display("FAIL reset_stays_idle busy=%b req=%b addr=%h expected 0 0 00", busy, imem_req, imem_addr);
            end
        end
    endtask

    task automatic test_alu_ops();
        int cyc;
        mem[0] = 8'h70; mem[1] = 8'h80; mem[2] = 8'h50; mem[3] = 8'hE0;
        for (int i = 0; i < 4; i++) exp_addr.push_back(8'(i));
        exp_wr.push_back('{1'b1, 1'b1, 2'b01, 1'b0, 8'h00});
        exp_wr.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 8'h00});
        exp_wr.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 8'h00});
        go(cyc);
        checks++;
        if (cyc != 11) begin
            errors++;
            $display("FAIL alu_latency got %0d cycles expected 11", cyc);
        end
        checks++;
        if (exp_addr.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL alu_drain addr_left=%0d wr_left=%0d expected 0", exp_addr.size(), exp_wr.size());
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        apply_reset();
        mem[0] = 8'h20; mem[1] = 8'hAA; mem[2] = 8'hE0;
        exp_addr.push_back(8'h00); exp_addr.push_back(8'h01); exp_addr.push_back(8'h02);
        exp_wr.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 8'hAA});
        ack_delay = 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || reg_we !== 1'b0) begin
                errors++;
                $display("FAIL wait_fetch cycle %0d req=%b addr=%h we=%b expected 1 00 0", i, imem_req, imem_addr, reg_we);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_decode req=%b busy=%b expected 0 1", imem_req, busy);
        end
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h01 || reg_we !== 1'b0) begin
                errors++;
                $display("FAIL wait_oper cycle %0d req=%b addr=%h we=%b expected 1 01 0", i, imem_req, imem_addr, reg_we);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (reg_we !== 1'b1 || imm !== 8'hAA) begin
            errors++;
            $display("FAIL wait_wb we=%b imm=%h expected 1 AA", reg_we, imm);
        end
        cyc = 0;
        while (halted !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        ack_delay = 0;
        checks++;
        if (halted !== 1'b1 || exp_addr.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL wait_drain halted=%b addr_left=%0d wr_left=%0d expected 1 0 0",
                     halted, exp_addr.size(), exp_wr.size());
        end
    endtask

    task automatic test_jz();
        logic [7:0] tbl_ir [4] = '{8'hD0, 8'hD0, 8'hC0, 8'hC0};
        logic [7:0] tbl_t1 [4] = '{8'h55, 8'h00, 8'h00, 8'h01};
        logic [7:0] tbl_t2 [4] = '{8'h00, 8'h01, 8'h55, 8'h00};
        logic [7:0] tbl_nx [4] = '{8'h10, 8'h02, 8'h10, 8'h02};
        int cyc;
        for (int c = 0; c < 4; c++) begin
            apply_reset();
            mem[0] = tbl_ir[c]; mem[1] = 8'h10; mem[2] = 8'hE0; mem[8'h10] = 8'hE0;
            temp1 = tbl_t1[c];
            temp2 = tbl_t2[c];
            exp_addr.push_back(8'h00); exp_addr.push_back(8'h01); exp_addr.push_back(tbl_nx[c]);
            go(cyc);
            checks++;
            if (cyc != 5 || imem_addr !== tbl_nx[c] + 8'h01 || exp_addr.size() != 0) begin
                errors++;
                $display("FAIL jz_case%0d cycles=%0d pc=%h left=%0d expected 5 %h 0",
                         c, cyc, imem_addr, exp_addr.size(), tbl_nx[c] + 8'h01);
            end
        end
        temp1 = 8'h00;
        temp2 = 8'h00;
    endtask

    task automatic test_pc_wrap();
        int cyc;
        apply_reset();
        mem[0] = 8'hA0; mem[1] = 8'hFF; mem[8'hFF] = 8'hE0;
        exp_addr.push_back(8'h00); exp_addr.push_back(8'h01); exp_addr.push_back(8'hFF);
        go(cyc);
        checks++;
        if (imem_addr !== 8'h00 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL wrap_jmp_ff pc=%h left=%0d expected 00 0", imem_addr, exp_addr.size());
        end
        mem[0] = 8'hA0; mem[1] = 8'hFE; mem[8'hFE] = 8'hE0;
        exp_addr.push_back(8'h00); exp_addr.push_back(8'h01); exp_addr.push_back(8'hFE);
        go(cyc);
        mem[8'hFF] = 8'h00; mem[0] = 8'hE0;
        exp_addr.push_back(8'hFF); exp_addr.push_back(8'h00);
        go(cyc);
        checks++;
        if (cyc != 4 || imem_addr !== 8'h01 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL wrap_nop_ff cycles=%0d pc=%h left=%0d expected 4 01 0", cyc, imem_addr, exp_addr.size());
        end
    endtask

    task automatic test_halt_start();
        int cyc;
        apply_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        mem[4] = 8'hE0; mem[5] = 8'h30; mem[6] = 8'h77; mem[7] = 8'hE0;
        for (int i = 0; i < 5; i++) exp_addr.push_back(8'(i));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        while (halted !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc != 10 || halted !== 1'b1 || busy !== 1'b0 || imem_addr !== 8'h05) begin
            errors++;
            $display("FAIL halt_reached cycles=%0d halted=%b busy=%b pc=%h expected 10 1 0 05",
                     cyc, halted, busy, imem_addr);
        end
        exp_addr.push_back(8'h05); exp_addr.push_back(8'h06); exp_addr.push_back(8'h07);
        exp_wr.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 8'h77});
        go(cyc);
        checks++;
        if (cyc != 6 || imem_addr !== 8'h08 || exp_addr.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL halt_restart cycles=%0d pc=%h addr_left=%0d wr_left=%0d expected 6 08 0 0",
                     cyc, imem_addr, exp_addr.size(), exp_wr.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
        test_reset();
        test_program();
        test_reset_mid_handshake();
        test_alu_ops();
        test_wait_states();
        test_jz();
        test_pc_wrap();
        test_halt_start();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
